parking_gate_arbiter: RTL
=========================

# parking_gate_arbiter

Sequencer for the single shared barrier gate of the parking lot. It takes debounced one-cycle request pulses from the entry and exit lanes and a debounced car-passed pulse. It arbitrates which lane is served, drives the barrier motor through open/hold/close phases, and maintains the occupancy count against a fixed capacity. It sits between the per-sensor debouncers and the gate motor driver and display logic.

## Interface
- CAPACITY, 8: number of parking spaces.
- CNT_W, 4: occupancy width; must satisfy 2^CNT_W > CAPACITY.
- MOVE_CYCLES, 80_000_000: clock cycles the motor takes to fully raise or lower the barrier (2 s at 40 MHz).
- TIMEOUT_CYCLES, 400_000_000: maximum hold time in OPEN with no car passing (10 s at 40 MHz).

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- entry_req  in  1  one-cycle pulse: car at entry lane.
- exit_req  in  1  one-cycle pulse: car at exit lane.
- pass_pulse  in  1  one-cycle pulse: car cleared the barrier.
- motor_up  out  1  high while the barrier is raising.
- motor_down  out  1  high while the barrier is lowering.
- gate_up  out  1  high while the barrier is held open.
- dir_entry  out  1  lane being served (1 = entry, 0 = exit); valid while not IDLE.
- occupancy  out  CNT_W  cars currently inside.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- reject  out  1  one-cycle pulse: pending request refused (entry when full, exit when empty).
- timeout  out  1  one-cycle pulse: OPEN ended without pass_pulse.

## Operation
- Pending flags entry_pend and exit_pend are set by the respective request pulse. A pulse arriving while its flag is already set is absorbed. Set wins over clear in the same cycle.
- FSM states: IDLE, OPENING, OPEN, CLOSING.
  - IDLE: if no flag is set, stay. Otherwise pick a lane. With one flag set, that lane is picked. With both set, the lane not served last is picked; exit has priority after reset.
    - If the picked lane is entry and full, or exit and empty: pulse reject, clear that flag, stay in IDLE.
    - Otherwise: clear the flag, latch dir_entry, update last-served, go to OPENING.
  - OPENING: motor_up=1 for exactly MOVE_CYCLES cycles, then go to OPEN.
  - OPEN: gate_up=1.
    - On pass_pulse: occupancy +1 if dir_entry, otherwise -1; go to CLOSING.
    - When TIMEOUT_CYCLES cycles elapse with no pass: pulse timeout, leave occupancy unchanged, go to CLOSING.
    - pass_pulse and timeout in the same cycle: pass wins and no timeout pulse is issued.
  - CLOSING: motor_down=1 for exactly MOVE_CYCLES cycles, then go to IDLE.
- pass_pulse outside OPEN is ignored.
- Requests arriving in any state only set flags. This includes a request for the lane currently being served.
- Occupancy saturates at 0 and at CAPACITY as a guard. The grant-time check already prevents overflow and underflow.
- One timer (32 bits) is shared by the OPENING, OPEN and CLOSING phases and cleared on each state change.
- motor_up, motor_down and gate_up are decoded from the state register. They are mutually exclusive and all 0 in IDLE.

## Timing
- Reset values: state IDLE, both flags 0, last-served = entry (so exit wins the first tie), occupancy 0, dir_entry 0. Outputs: motor_up 0, motor_down 0, gate_up 0, reject 0, timeout 0, full 0, empty 1.
- A request pulse in cycle t sets its flag at t+1. The IDLE decision happens in t+1. motor_up rises in t+2. A reject pulse is asserted in t+2.
- Full cycle with a car passing: 2·MOVE_CYCLES cycles of motion plus the time in OPEN plus 1 IDLE decision cycle.
- occupancy, full and empty update in the cycle after pass_pulse is sampled in OPEN, coincident with motor_down rising.
- reject and timeout are registered pulses, exactly 1 cycle wide.
- Reset asserted mid-operation returns the block to the reset state immediately, including occupancy. Pending requests are lost.

## Configuration
- PARK_TIMEOUT_EN defined: OPEN timeout behaves as described above.
- PARK_TIMEOUT_EN undefined: OPEN waits indefinitely for pass_pulse and timeout is tied to 0. The timer is used only for the motion phases.

## Test plan
All scenarios use CAPACITY=2, MOVE_CYCLES=4, TIMEOUT_CYCLES=10, PARK_TIMEOUT_EN defined.
- Reset, then an entry_req pulse, then pass_pulse 3 cycles into OPEN:
  - motor_up high for 4 cycles starting 2 cycles after the request;
  - occupancy becomes 1 and motor_down is high for 4 cycles;
  - the block returns to IDLE.
- entry_req and exit_req in the same cycle with occupancy=1: exit is served first (dir_entry=0, occupancy→0 after its pass), then entry is served (occupancy→1).
- Two entries completed (full=1), then entry_req: reject pulses once, 2 cycles after the request; no motor activity; occupancy stays 2.
- exit_req at reset (empty=1): reject pulses once and the gate stays idle.
- entry_req with no pass_pulse: timeout pulses after 10 cycles in OPEN, CLOSING follows, occupancy unchanged. Repeated with PARK_TIMEOUT_EN undefined: gate_up stays high for 100+ cycles until pass_pulse.
- reset_n dropped during OPEN with occupancy=1 and exit_pend set: all outputs return to reset values asynchronously; no grant after reset is released.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// Shared barrier-gate sequencer: lane arbitration, motor phasing and occupancy count.
// Define PARK_TIMEOUT_EN to make OPEN give up after TIMEOUT_CYCLES without a passing car.
module parking_gate_arbiter #(
  parameter int CAPACITY       = 8,
  parameter int CNT_W          = 4,
  parameter int MOVE_CYCLES    = 80_000_000,
  parameter int TIMEOUT_CYCLES = 400_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pass_pulse,
  output logic             motor_up,
  output logic             motor_down,
  output logic             gate_up,
  output logic             dir_entry,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             reject,
  output logic             timeout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OPENING = 2'd1;
  localparam logic [1:0] ST_OPEN    = 2'd2;
  localparam logic [1:0] ST_CLOSING = 2'd3;

  localparam logic [31:0]      MOVE_LAST = 32'(MOVE_CYCLES - 1);
  localparam logic [31:0]      TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);

  logic [1:0]       state_q, state_d;
  logic [31:0]      timer_q, timer_d;
  logic             entry_pend_q, entry_pend_d;
  logic             exit_pend_q, exit_pend_d;
  logic             last_entry_q, last_entry_d;
  logic             dir_entry_q, dir_entry_d;
  logic [CNT_W-1:0] occupancy_q, occupancy_d;
  logic             reject_q, reject_d;
  logic             timeout_q, timeout_d;
  logic             clr_entry, clr_exit;
  logic             pick_entry;
  logic             full_w, empty_w;

  assign full_w  = (occupancy_q == CAP_VAL);
  assign empty_w = (occupancy_q == '0);

  // On a tie, serve the lane that was not served last.
  assign pick_entry = entry_pend_q & (~exit_pend_q | ~last_entry_q);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    last_entry_d = last_entry_q;
    dir_entry_d  = dir_entry_q;
    occupancy_d  = occupancy_q;
    reject_d     = 1'b0;
    timeout_d    = 1'b0;
    clr_entry    = 1'b0;
    clr_exit     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (entry_pend_q || exit_pend_q) begin
          clr_entry = pick_entry;
          clr_exit  = ~pick_entry;
          if ((pick_entry && full_w) || (!pick_entry && empty_w)) begin
            reject_d = 1'b1;
          end else begin
            dir_entry_d  = pick_entry;
            last_entry_d = pick_entry;
            state_d      = ST_OPENING;
          end
        end
      end
      ST_OPENING: begin
        if (timer_q == MOVE_LAST) begin
          timer_d = '0;
          state_d = ST_OPEN;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_OPEN: begin
        if (pass_pulse) begin
          // Saturating update guards against a count drifting past its bounds.
          if (dir_entry_q && !full_w)
            occupancy_d = occupancy_q + CNT_W'(1);
          else if (!dir_entry_q && !empty_w)
            occupancy_d = occupancy_q - CNT_W'(1);
          timer_d = '0;
          state_d = ST_CLOSING;
        end
`ifdef PARK_TIMEOUT_EN
        else if (timer_q == TO_LAST) begin
          timeout_d = 1'b1;
          timer_d   = '0;
          state_d   = ST_CLOSING;
        end else begin
          timer_d = timer_q + 32'd1;
        end
`else
        else begin
          timer_d = (TO_LAST == 32'd0) ? '0 : '0;
        end
`endif
      end
      ST_CLOSING: begin
        if (timer_q == MOVE_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    // A fresh request wins over the grant-time clear.
    entry_pend_d = entry_req | (entry_pend_q & ~clr_entry);
    exit_pend_d  = exit_req  | (exit_pend_q  & ~clr_exit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      entry_pend_q <= 1'b0;
      exit_pend_q  <= 1'b0;
      last_entry_q <= 1'b1;
      dir_entry_q  <= 1'b0;
      occupancy_q  <= '0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      entry_pend_q <= entry_pend_d;
      exit_pend_q  <= exit_pend_d;
      last_entry_q <= last_entry_d;
      dir_entry_q  <= dir_entry_d;
      occupancy_q  <= occupancy_d;
      reject_q     <= reject_d;
      timeout_q    <= timeout_d;
    end
  end

  assign motor_up   = (state_q == ST_OPENING);
  assign motor_down = (state_q == ST_CLOSING);
  assign gate_up    = (state_q == ST_OPEN);
  assign dir_entry  = dir_entry_q;
  assign occupancy  = occupancy_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign reject     = reject_q;
  assign timeout    = timeout_q;

endmodule
